// File: rtl/sram_arbiter_if.sv
// Bus bundle for the two-port SRAM arbiter: requester handshakes plus the SRAM pins.
// slave = arbiter side, master = requesters and SRAM device side.
interface sram_arbiter_if #(
  parameter int AW = 21,
  parameter int DW = 8
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [AW-1:0] SRAM_A;
  logic [DW-1:0] sram_dq_o;
  logic [DW-1:0] sram_dq_i;
  logic          sram_dq_oe;
  logic          SRAM_nCE;
  logic          SRAM_nOE;
  logic          SRAM_nWE;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_dq_i,
    output ack0, ack1, rdata, busy, SRAM_A, sram_dq_o, sram_dq_oe,
           SRAM_nCE, SRAM_nOE, SRAM_nWE
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_dq_i,
    input  ack0, ack1, rdata, busy, SRAM_A, sram_dq_o, sram_dq_oe,
           SRAM_nCE, SRAM_nOE, SRAM_nWE
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port asynchronous SRAM arbiter (port 0 video/DMA, port 1 CPU) with registered strobes.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise port 0 has fixed priority.
//
// state  | meaning
// IDLE   | waiting for a request; grant and transaction fields latched on exit
// SETUP  | address valid, nCE low; nOE low for reads, data driven for writes
// STROBE | WAIT_CYCLES cycles of nOE (read) or nWE (write) low
// DONE   | strobes released, ack pulse; writes keep nCE/data for hold time
module sram_arbiter #(
  parameter int AW          = 21,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk_sys,
  input  logic          reset,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  localparam logic [3:0] STROBE_LOAD = 4'(WAIT_CYCLES - 1);

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          grant, grant_nxt;
  logic          lat_we, lat_we_nxt;
  logic [AW-1:0] addr_nxt;
  logic [DW-1:0] wdata_nxt;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic          last_grant, last_grant_nxt;

  always_ff @(posedge clk_sys) begin
    if (reset) last_grant <= 1'b1;
    else       last_grant <= last_grant_nxt;
  end
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      grant  <= 1'b0;
      lat_we <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      grant  <= grant_nxt;
      lat_we <= lat_we_nxt;
    end
  end

  // SRAM_A and sram_dq_o double as the latched address and write data.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    grant_nxt  = grant;
    lat_we_nxt = lat_we;
    addr_nxt   = bus.SRAM_A;
    wdata_nxt  = bus.sram_dq_o;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    last_grant_nxt = last_grant;
`endif
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
          grant_nxt      = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
          last_grant_nxt = grant_nxt;
`else
          grant_nxt      = ~bus.req0;
`endif
          lat_we_nxt = grant_nxt ? bus.we1    : bus.we0;
          addr_nxt   = grant_nxt ? bus.addr1  : bus.addr0;
          wdata_nxt  = grant_nxt ? bus.wdata1 : bus.wdata0;
          state_nxt  = SETUP;
        end
      end
      SETUP: begin
        cnt_nxt   = STROBE_LOAD;
        state_nxt = STROBE;
      end
      STROBE: begin
        if (cnt == 4'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every pin comes straight from a flop.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bus.SRAM_A     <= '0;
      bus.sram_dq_o  <= '0;
      bus.sram_dq_oe <= 1'b0;
      bus.SRAM_nCE   <= 1'b1;
      bus.SRAM_nOE   <= 1'b1;
      bus.SRAM_nWE   <= 1'b1;
      bus.ack0       <= 1'b0;
      bus.ack1       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.rdata      <= '0;
    end else begin
      bus.SRAM_A     <= addr_nxt;
      bus.sram_dq_o  <= wdata_nxt;
      bus.sram_dq_oe <= lat_we_nxt && (state_nxt != IDLE);
      bus.SRAM_nCE   <= !((state_nxt == SETUP) || (state_nxt == STROBE) ||
                          ((state_nxt == DONE) && lat_we_nxt));
      bus.SRAM_nOE   <= !(!lat_we_nxt && ((state_nxt == SETUP) || (state_nxt == STROBE)));
      bus.SRAM_nWE   <= !(lat_we_nxt && (state_nxt == STROBE));
      bus.ack0       <= (state_nxt == DONE) && !grant_nxt;
      bus.ack1       <= (state_nxt == DONE) && grant_nxt;
      bus.busy       <= (state_nxt != IDLE);
      if ((state == STROBE) && (state_nxt == DONE) && !lat_we)
        bus.rdata <= bus.sram_dq_i;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: WAIT_CYCLES=1 instance for the main sequence and a
// WAIT_CYCLES=15 instance for long strobes; expected acks flow through a scoreboard queue.
`define CHECK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp); end end

module tb_sram_arbiter;
  localparam int AW = 21;
  localparam int DW = 8;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  sram_arbiter_if #(.AW(AW), .DW(DW)) ia ();
  sram_arbiter_if #(.AW(AW), .DW(DW)) ib ();

  sram_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(1)) dut_a (
    .clk_sys(clk_sys), .reset(reset), .bus(ia.slave));
  sram_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(15)) dut_b (
    .clk_sys(clk_sys), .reset(reset), .bus(ib.slave));

  int errors = 0;
  int checks = 0;

  // SRAM model for instance A: rom holds preloaded contents, mem holds written data.
  logic [7:0] rom [int];
  logic [7:0] mem [int];

  always @(posedge clk_sys)
    if (!ia.SRAM_nCE && !ia.SRAM_nWE && ia.sram_dq_oe) mem[int'(ia.SRAM_A)] = ia.sram_dq_o;

  always @(negedge clk_sys) begin
    if (ia.SRAM_nCE || ia.SRAM_nOE)          ia.sram_dq_i = 8'h00;
    else if (mem.exists(int'(ia.SRAM_A)))    ia.sram_dq_i = mem[int'(ia.SRAM_A)];
    else if (rom.exists(int'(ia.SRAM_A)))    ia.sram_dq_i = rom[int'(ia.SRAM_A)];
    else                                     ia.sram_dq_i = 8'h00;
  end

  always @(negedge clk_sys)
    ib.sram_dq_i = (!ib.SRAM_nCE && !ib.SRAM_nOE) ? 8'hC3 : 8'h00;

  typedef struct {
    logic       port;
    logic       is_read;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic push_exp(input logic port, input logic is_read, input logic [7:0] data);
    exp_t e;
    e.port = port; e.is_read = is_read; e.data = data;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    `CHECK("ack_excl_a", ia.ack0 & ia.ack1, 1'b0);
    `CHECK("strobe_excl_a", ~ia.SRAM_nOE & ~ia.SRAM_nWE, 1'b0);
    `CHECK("ack_excl_b", ib.ack0 & ib.ack1, 1'b0);
    `CHECK("strobe_excl_b", ~ib.SRAM_nOE & ~ib.SRAM_nWE, 1'b0);
  endtask

  task automatic wait_ack(input int budget, output int cyc);
    exp_t e;
    logic got;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < budget) begin
      tick();
      cyc++;
      if (sb.size() > 0 && sb[0].is_read) `CHECK("dq_oe_read", ia.sram_dq_oe, 1'b0);
      if (ia.ack0 || ia.ack1) begin
        got = 1'b1;
        if (sb.size() == 0) begin
          checks++; errors++;
          $error("FAIL sb_empty: observed=ack expected=no ack");
        end else begin
          e = sb.pop_front();
          `CHECK("ack_port", ia.ack1, e.port);
          if (e.is_read) `CHECK("rdata", ia.rdata, e.data);
        end
      end
    end
    if (!got) begin
      checks++; errors++;
      $error("FAIL ack_timeout: observed=no ack expected=ack within %0d cycles", budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int low_run;
    int max_run;
    int ack_cyc;

    ia.req0 = 0; ia.req1 = 0; ia.we0 = 0; ia.we1 = 0;
    ia.addr0 = '0; ia.addr1 = '0; ia.wdata0 = '0; ia.wdata1 = '0;
    ib.req0 = 0; ib.req1 = 0; ib.we0 = 0; ib.we1 = 0;
    ib.addr0 = '0; ib.addr1 = '0; ib.wdata0 = '0; ib.wdata1 = '0;
    rom[32'h12345] = 8'h5A;
    rom[32'h00010] = 8'h11;
    rom[32'h00020] = 8'h22;

    // reset state
    reset = 1'b1;
    tick(); tick();
    `CHECK("rst_busy", ia.busy, 1'b0);
    `CHECK("rst_nce", ia.SRAM_nCE, 1'b1);
    `CHECK("rst_noe", ia.SRAM_nOE, 1'b1);
    `CHECK("rst_nwe", ia.SRAM_nWE, 1'b1);
    `CHECK("rst_dq_oe", ia.sram_dq_oe, 1'b0);
    `CHECK("rst_acks", {ia.ack0, ia.ack1}, 2'b00);
    `CHECK("rst_rdata", ia.rdata, 8'h00);
    `CHECK("rst_addr", ia.SRAM_A, 21'h0);
    `CHECK("rst_dq_o", ia.sram_dq_o, 8'h00);
    `CHECK("rst_busy_b", ib.busy, 1'b0);
    reset = 1'b0;
    tick();

    // single read on port 0
    ia.req0 = 1; ia.we0 = 0; ia.addr0 = 21'h12345;
    push_exp(1'b0, 1'b1, 8'h5A);
    wait_ack(10, cyc);
    `CHECK("read_latency", cyc, 3);
    ia.req0 = 0;
    tick();
    `CHECK("read_ack_width", ia.ack0, 1'b0);
    `CHECK("read_rdata_hold", ia.rdata, 8'h5A);
    `CHECK("read_idle_busy", ia.busy, 1'b0);

    // single write on port 1, checked phase by phase
    ia.req1 = 1; ia.we1 = 1; ia.addr1 = 21'h12345; ia.wdata1 = 8'hA5;
    tick();
    `CHECK("wr_setup_nce", ia.SRAM_nCE, 1'b0);
    `CHECK("wr_setup_oe", ia.sram_dq_oe, 1'b1);
    `CHECK("wr_setup_nwe", ia.SRAM_nWE, 1'b1);
    `CHECK("wr_setup_noe", ia.SRAM_nOE, 1'b1);
    `CHECK("wr_setup_addr", ia.SRAM_A, 21'h12345);
    `CHECK("wr_setup_data", ia.sram_dq_o, 8'hA5);
    `CHECK("wr_setup_busy", ia.busy, 1'b1);
    tick();
    `CHECK("wr_strobe_nwe", ia.SRAM_nWE, 1'b0);
    `CHECK("wr_strobe_nce", ia.SRAM_nCE, 1'b0);
    `CHECK("wr_strobe_oe", ia.sram_dq_oe, 1'b1);
    tick();
    `CHECK("wr_done_ack1", ia.ack1, 1'b1);
    `CHECK("wr_done_nwe", ia.SRAM_nWE, 1'b1);
    `CHECK("wr_done_oe", ia.sram_dq_oe, 1'b1);
    `CHECK("wr_done_nce", ia.SRAM_nCE, 1'b0);
    ia.req1 = 0;
    tick();
    `CHECK("wr_idle_strobes", {ia.SRAM_nCE, ia.SRAM_nOE, ia.SRAM_nWE}, 3'b111);
    `CHECK("wr_idle_oe", ia.sram_dq_oe, 1'b0);
    `CHECK("wr_idle_ack", ia.ack1, 1'b0);
    `CHECK("wr_mem", mem[32'h12345], 8'hA5);
    `CHECK("wr_rdata_kept", ia.rdata, 8'h5A);

    // early drop of req1 during SETUP
    ia.req1 = 1; ia.we1 = 1; ia.addr1 = 21'h00100; ia.wdata1 = 8'h3C;
    push_exp(1'b1, 1'b0, 8'h00);
    tick();
    ia.req1 = 0;
    wait_ack(5, cyc);
    `CHECK("drop_latency", cyc, 2);
    tick();
    `CHECK("drop_mem", mem[32'h00100], 8'h3C);
    `CHECK("drop_rdata_kept", ia.rdata, 8'h5A);

    // contention: both ports request reads continuously
    ia.req0 = 1; ia.we0 = 0; ia.addr0 = 21'h00010;
    ia.req1 = 1; ia.we1 = 0; ia.addr1 = 21'h00020;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    push_exp(1'b0, 1'b1, 8'h11);
    push_exp(1'b1, 1'b1, 8'h22);
    push_exp(1'b0, 1'b1, 8'h11);
    push_exp(1'b1, 1'b1, 8'h22);
`else
    for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b1, 8'h11);
`endif
    wait_ack(10, cyc);
    `CHECK("cont_first", cyc, 3);
    for (int i = 0; i < 3; i++) begin
      wait_ack(10, cyc);
      `CHECK("cont_spacing", cyc, 4);
    end
    ia.req0 = 0; ia.req1 = 0;
    tick();
    `CHECK("cont_idle", ia.busy, 1'b0);
    `CHECK("sb_drained", sb.size(), 0);

    // reset during STROBE of a write aborts it
    ia.req1 = 1; ia.we1 = 1; ia.addr1 = 21'h00200; ia.wdata1 = 8'h77;
    tick();
    tick();
    `CHECK("abort_strobe_nwe", ia.SRAM_nWE, 1'b0);
    reset = 1'b1;
    ia.req1 = 0;
    tick();
    `CHECK("abort_nwe", ia.SRAM_nWE, 1'b1);
    `CHECK("abort_nce", ia.SRAM_nCE, 1'b1);
    `CHECK("abort_oe", ia.sram_dq_oe, 1'b0);
    `CHECK("abort_busy", ia.busy, 1'b0);
    `CHECK("abort_ack", ia.ack1, 1'b0);
    reset = 1'b0;
    tick(); tick();
    `CHECK("abort_no_late_ack", ia.ack1, 1'b0);
    `CHECK("abort_idle", ia.busy, 1'b0);

    // WAIT_CYCLES=15 read on instance B
    ib.req0 = 1; ib.we0 = 0; ib.addr0 = 21'h00055;
    low_run = 0; max_run = 0; ack_cyc = -1;
    for (int c = 1; c <= 30 && ack_cyc < 0; c++) begin
      tick();
      if (!ib.SRAM_nOE) low_run++;
      else low_run = 0;
      if (low_run > max_run) max_run = low_run;
      `CHECK("long_dq_oe", ib.sram_dq_oe, 1'b0);
      if (ib.ack0) ack_cyc = c;
    end
    `CHECK("long_noe_run", max_run, 16);
    `CHECK("long_ack_cycle", ack_cyc, 17);
    `CHECK("long_rdata", ib.rdata, 8'hC3);
    ib.req0 = 0;
    tick();
    `CHECK("long_ack_width", ib.ack0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
